biriscv_v_writeback: RTL and testbench

BIRISCV_V_WRITEBACK -- requirements
Module: biriscv_v_writeback

---
 rtl/biriscv_v_writeback_pkg.sv | 21 ++
 rtl/biriscv_v_wb_fifo.sv | 81 ++++++++
 rtl/biriscv_v_writeback.sv | 86 ++++++++
 tb/tb_biriscv_v_writeback.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_v_writeback_pkg.sv
// Shared vector definitions for the writeback stage: default widths,
// the queue occupancy states and the {vd, value, elem_en} entry layout.
package biriscv_v_writeback_pkg;

  localparam int VLEN_DEF = 128;
  localparam int ELEN_DEF = 32;
  localparam int NE_DEF   = VLEN_DEF / ELEN_DEF;
  localparam int VD_W     = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_count_e;

  // Entry is packed MSB-first as {vd_idx, value, elem_en}.
  function automatic int entry_width(input int vlen, input int elen);
    return VD_W + vlen + (vlen / elen);
  endfunction

endpackage

// File: rtl/biriscv_v_wb_fifo.sv
// Two-deep result queue; owns pointer and occupancy logic and exposes each
// slot's tag so the parent can build its pending-register bitmap.
module biriscv_v_wb_fifo
  import biriscv_v_writeback_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output wb_count_e        count_o,
  output logic [1:0]       slot_valid_o,
  output logic [TAG_W-1:0] slot0_tag_o,
  output logic [TAG_W-1:0] slot1_tag_o
);

  wb_count_e        count_q, count_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [2];
  logic             push_w, pop_w;

  assign pop_w  = pop_i & (count_q != EMPTY);
  assign push_w = push_i & ((count_q != FULL) | pop_w);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = EMPTY;
    end else begin
      case ({push_w, pop_w})
        2'b10:   count_d = (count_q == EMPTY) ? ONE : FULL;
        2'b01:   count_d = (count_q == FULL) ? ONE : EMPTY;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push_w) begin
          mem_q[wr_ptr_q] <= data_i;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop_w) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  always_comb begin
    slot_valid_o = 2'b00;
    case (count_q)
      FULL:    slot_valid_o = 2'b11;
      ONE:     slot_valid_o = rd_ptr_q ? 2'b10 : 2'b01;
      default: slot_valid_o = 2'b00;
    endcase
  end

  assign head_o      = (count_q != EMPTY) ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;
  assign slot0_tag_o = mem_q[0][WIDTH-1 -: TAG_W];
  assign slot1_tag_o = mem_q[1][WIDTH-1 -: TAG_W];

endmodule

// File: rtl/biriscv_v_writeback.sv
// Vector writeback stage: queues ALU results, drains them into the vector
// register file in order, and reports retirement and pending destinations.
module biriscv_v_writeback
  import biriscv_v_writeback_pkg::*;
#(
  parameter  int VLEN = VLEN_DEF,
  parameter  int ELEN = ELEN_DEF,
  localparam int NE   = VLEN / ELEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            result_valid_i,
  output logic            result_ready_o,
  input  logic [4:0]      result_vd_idx_i,
  input  logic [VLEN-1:0] result_value_i,
  input  logic [NE-1:0]   result_elem_en_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            vrf_wr_en_o,
  input  logic            vrf_wr_ready_i,
  output logic [4:0]      vrf_wr_idx_o,
  output logic [VLEN-1:0] vrf_wr_data_o,
  output logic [NE-1:0]   vrf_wr_elem_en_o,
  output logic [31:0]     pending_vd_o,
  output logic            complete_o
);

  localparam int EW = entry_width(VLEN, ELEN);

  wb_count_e       count_w;
  logic [EW-1:0]   head_w;
  logic [1:0]      slot_valid_w;
  logic [VD_W-1:0] slot0_vd_w, slot1_vd_w;
  logic            pop_w, push_w, accept_w, zero_accept_w;
  logic [1:0]      cmp_cnt_q, cmp_cnt_d;
  logic [2:0]      cmp_sum_w;

  assign vrf_wr_en_o    = (count_w != EMPTY) & ~hold_i & ~flush_i;
  assign pop_w          = vrf_wr_en_o & vrf_wr_ready_i;
  assign result_ready_o = rst_ni & ~flush_i & ~hold_i & ((count_w != FULL) | pop_w);
  assign accept_w       = result_valid_i & result_ready_o;
  assign push_w         = accept_w & (|result_elem_en_i);
  assign zero_accept_w  = accept_w & ~(|result_elem_en_i);

  biriscv_v_wb_fifo #(
    .WIDTH (EW),
    .TAG_W (VD_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_i       (push_w),
    .pop_i        (pop_w),
    .data_i       ({result_vd_idx_i, result_value_i, result_elem_en_i}),
    .head_o       (head_w),
    .count_o      (count_w),
    .slot_valid_o (slot_valid_w),
    .slot0_tag_o  (slot0_vd_w),
    .slot1_tag_o  (slot1_vd_w)
  );

  assign {vrf_wr_idx_o, vrf_wr_data_o, vrf_wr_elem_en_o} = head_w;

  always_comb begin
    pending_vd_o = '0;
    if (slot_valid_w[0]) pending_vd_o[slot0_vd_w] = 1'b1;
    if (slot_valid_w[1]) pending_vd_o[slot1_vd_w] = 1'b1;
    if (push_w)          pending_vd_o[result_vd_idx_i] = 1'b1;
  end

  // A pop and a zero-enable accept can coincide, so retirements are counted
  // and drained one pulse per cycle; the count saturates at its 2-bit limit.
  always_comb begin
    cmp_sum_w = {1'b0, cmp_cnt_q} - {2'b00, |cmp_cnt_q}
              + {2'b00, pop_w} + {2'b00, zero_accept_w};
    cmp_cnt_d = (cmp_sum_w > 3'd3) ? 2'd3 : cmp_sum_w[1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cmp_cnt_q <= 2'd0;
    else         cmp_cnt_q <= cmp_cnt_d;
  end

  assign complete_o = |cmp_cnt_q;

endmodule

// File: tb/tb_biriscv_v_writeback.sv
// Self-checking bench for biriscv_v_writeback: directed scenarios pinned with
// literal expectations plus randomized traffic against a queue-based model.
module tb_biriscv_v_writeback;

  localparam int VLEN = 128;
  localparam int NE   = 4;

  logic            clk_i, rst_ni;
  logic            result_valid_i, result_ready_o;
  logic [4:0]      result_vd_idx_i;
  logic [VLEN-1:0] result_value_i;
  logic [NE-1:0]   result_elem_en_i;
  logic            hold_i, flush_i;
  logic            vrf_wr_en_o, vrf_wr_ready_i;
  logic [4:0]      vrf_wr_idx_o;
  logic [VLEN-1:0] vrf_wr_data_o;
  logic [NE-1:0]   vrf_wr_elem_en_o;
  logic [31:0]     pending_vd_o;
  logic            complete_o;

  biriscv_v_writeback dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .result_valid_i   (result_valid_i),
    .result_ready_o   (result_ready_o),
    .result_vd_idx_i  (result_vd_idx_i),
    .result_value_i   (result_value_i),
    .result_elem_en_i (result_elem_en_i),
    .hold_i           (hold_i),
    .flush_i          (flush_i),
    .vrf_wr_en_o      (vrf_wr_en_o),
    .vrf_wr_ready_i   (vrf_wr_ready_i),
    .vrf_wr_idx_o     (vrf_wr_idx_o),
    .vrf_wr_data_o    (vrf_wr_data_o),
    .vrf_wr_elem_en_o (vrf_wr_elem_en_o),
    .pending_vd_o     (pending_vd_o),
    .complete_o       (complete_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]      vd;
    logic [VLEN-1:0] val;
    logic [NE-1:0]   en;
  } ent_t;

  ent_t q[$];
  int   pend_cmp;
  int   checks, errors;
  logic m_push, m_pop, m_flush;
  int   m_events;
  ent_t m_in;

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs come from the queue contents and this cycle's inputs.
  task automatic checkOutput();
    int          n;
    logic        e_pop, e_ready, accept, e_push, zero_acc;
    logic [31:0] e_pend;
    ent_t        head;
    n        = q.size();
    e_pop    = rst_ni && n > 0 && !hold_i && !flush_i && vrf_wr_ready_i;
    e_ready  = rst_ni && !flush_i && !hold_i && (n < 2 || e_pop);
    accept   = result_valid_i && e_ready;
    e_push   = accept && (result_elem_en_i != 0);
    zero_acc = accept && (result_elem_en_i == 0);
    e_pend   = '0;
    foreach (q[i]) e_pend[q[i].vd] = 1'b1;
    if (e_push) e_pend[result_vd_idx_i] = 1'b1;
    head.vd = '0; head.val = '0; head.en = '0;
    if (n > 0) head = q[0];
    chk("ready", result_ready_o, e_ready);
    chk("wr_en", vrf_wr_en_o, rst_ni && n > 0 && !hold_i && !flush_i);
    chk("wr_idx", vrf_wr_idx_o, head.vd);
    chk("wr_data", vrf_wr_data_o, head.val);
    chk("wr_elem_en", vrf_wr_elem_en_o, head.en);
    chk("pending", pending_vd_o, e_pend);
    chk("complete", complete_o, pend_cmp > 0);
    m_push   = e_push;
    m_pop    = e_pop;
    m_flush  = flush_i;
    m_events = int'(e_pop) + int'(zero_acc);
    m_in.vd  = result_vd_idx_i;
    m_in.val = result_value_i;
    m_in.en  = result_elem_en_i;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] vd, input logic [VLEN-1:0] val,
                               input logic [NE-1:0] en, input logic hold, input logic flush,
                               input logic rdy);
    result_valid_i   = v;
    result_vd_idx_i  = vd;
    result_value_i   = val;
    result_elem_en_i = en;
    hold_i           = hold;
    flush_i          = flush;
    vrf_wr_ready_i   = rdy;
    #1;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (m_flush) q.delete();
    else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(m_in);
    end
    pend_cmp = pend_cmp - (pend_cmp > 0 ? 1 : 0) + m_events;
    if (pend_cmp > 3) pend_cmp = 3;
    @(negedge clk_i);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 5'd0, '0, '0, 1'b0, 1'b0, rdy);
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    result_valid_i = 1'b0; result_vd_idx_i = '0; result_value_i = '0;
    result_elem_en_i = '0; hold_i = 1'b0; flush_i = 1'b0; vrf_wr_ready_i = 1'b0;
    q.delete();
    pend_cmp = 0;
    #1;
    checkOutput();
    chk("rst_ready", result_ready_o, 1'b0);
    chk("rst_complete", complete_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  logic [VLEN-1:0] v38;

  initial begin
    checks = 0; errors = 0; pend_cmp = 0;
    doReset();

    // Single push with all elements enabled
    v38 = {32'h4, 32'h3, 32'h2, 32'h1};
    applyStimulus(1'b1, 5'd3, v38, 4'b1111, 1'b0, 1'b0, 1'b1);
    chk("p1_ready", result_ready_o, 1'b1);
    chk("p1_pend_in", pending_vd_o, 32'h8);
    tick();
    idle(1'b1);
    chk("p1_wr_en", vrf_wr_en_o, 1'b1);
    chk("p1_idx", vrf_wr_idx_o, 5'd3);
    chk("p1_data", vrf_wr_data_o, v38);
    chk("p1_cmp0", complete_o, 1'b0);
    tick();
    idle(1'b1);
    chk("p1_cmp1", complete_o, 1'b1);
    chk("p1_pend_clr", pending_vd_o, 32'h0);
    tick();
    idle(1'b1);
    chk("p1_cmp_end", complete_o, 1'b0);
    tick();

    // Back-pressure: third push refused, then in-order drain
    applyStimulus(1'b1, 5'd1, 128'h11, 4'b0001, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy1", result_ready_o, 1'b1); tick();
    applyStimulus(1'b1, 5'd2, 128'h22, 4'b0011, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy2", result_ready_o, 1'b1); tick();
    applyStimulus(1'b1, 5'd7, 128'h33, 4'b0111, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy3", result_ready_o, 1'b0);
    chk("bp_pend", pending_vd_o, 32'h6); tick();
    idle(1'b1); chk("bp_first", vrf_wr_idx_o, 5'd1); tick();
    idle(1'b1); chk("bp_second", vrf_wr_idx_o, 5'd2); tick();
    idle(1'b1); chk("bp_empty", vrf_wr_en_o, 1'b0); tick();

    // Push and pop together while full
    applyStimulus(1'b1, 5'd1, 128'hA1, 4'b1000, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 5'd2, 128'hA2, 4'b0100, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 5'd6, 128'hA6, 4'b0010, 1'b0, 1'b0, 1'b1);
    chk("ff_ready", result_ready_o, 1'b1);
    chk("ff_idx", vrf_wr_idx_o, 5'd1); tick();
    idle(1'b0);
    chk("ff_still_full", result_ready_o, 1'b0);
    chk("ff_pend", pending_vd_o, 32'h44); tick();
    idle(1'b1); chk("ff_2nd", vrf_wr_idx_o, 5'd2); tick();
    idle(1'b1); chk("ff_3rd", vrf_wr_idx_o, 5'd6); tick();
    repeat (3) begin idle(1'b1); tick(); end

    // Zero-enable result retires without a write
    applyStimulus(1'b1, 5'd7, 128'h77, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("z_pend", pending_vd_o, 32'h0); tick();
    idle(1'b1);
    chk("z_wr_en", vrf_wr_en_o, 1'b0);
    chk("z_cmp", complete_o, 1'b1); tick();
    idle(1'b1); chk("z_cmp_once", complete_o, 1'b0); tick();

    // Flush of a full queue
    applyStimulus(1'b1, 5'd4, 128'h44, 4'b1111, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 5'd9, 128'h99, 4'b1111, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 5'd0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("fl_wr_en", vrf_wr_en_o, 1'b0);
    chk("fl_ready", result_ready_o, 1'b0); tick();
    idle(1'b1);
    chk("fl_after_wr", vrf_wr_en_o, 1'b0);
    chk("fl_after_pend", pending_vd_o, 32'h0);
    chk("fl_after_cmp", complete_o, 1'b0); tick();
    idle(1'b1); chk("fl_no_cmp", complete_o, 1'b0); tick();

    // Reset during an active write, after a hold
    applyStimulus(1'b1, 5'd8, 128'h88, 4'b1111, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 5'd10, 128'hAA, 4'b1111, 1'b1, 1'b0, 1'b1);
    chk("h_wr_en", vrf_wr_en_o, 1'b0);
    chk("h_ready", result_ready_o, 1'b0); tick();
    idle(1'b1);
    chk("h_release_wr", vrf_wr_en_o, 1'b1);
    chk("h_release_idx", vrf_wr_idx_o, 5'd8);
    doReset();
    idle(1'b1);
    chk("r_no_cmp", complete_o, 1'b0);
    chk("r_no_wr", vrf_wr_en_o, 1'b0); tick();
    applyStimulus(1'b1, 5'd5, 128'h55, 4'b1111, 1'b0, 1'b0, 1'b1); tick();
    idle(1'b1);
    chk("r_wr_en", vrf_wr_en_o, 1'b1);
    chk("r_idx", vrf_wr_idx_o, 5'd5); tick();
    idle(1'b1); chk("r_cmp", complete_o, 1'b1); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                    {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 1) == 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
